// File: rtl/sram_rw_port_ctrl.sv
// Initiator-side controller for a single-port masked-write SRAM macro: request
// channel in, macro RW0 port out, buffered in-order read responses back.
module sram_rw_port_ctrl #(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 8,
  parameter int MASK_W        = 4,
  parameter int RESP_DEPTH    = 3,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int OCC_W = $clog2(RESP_DEPTH + 2);
  localparam logic [OCC_W-1:0] DEPTH_L   = OCC_W'(RESP_DEPTH);
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(RESP_DEPTH - 1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] init_ptr_reg, init_ptr_next;
  logic              init_done_reg, init_done_next;
  logic              inflight_reg;

  logic [DATA_W-1:0] fifo_mem [RESP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [OCC_W-1:0]  occ_reg;
  logic [OCC_W-1:0]  pending;

  logic accept;
  logic push;
  logic pop;

  function automatic logic [PTR_W-1:0] next_slot(input logic [PTR_W-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + 1'b1;
  endfunction

  // Reads accepted but not yet handed back; the FIFO always has room for them.
  assign pending   = occ_reg + OCC_W'(inflight_reg);
  assign req_ready = init_done_reg && !reset && (pending < DEPTH_L);
  assign accept    = req_valid && req_ready;

  assign push       = inflight_reg;
  assign resp_valid = (occ_reg != '0);
  assign pop        = resp_valid && resp_ready;
  assign resp_rdata = resp_valid ? fifo_mem[rd_ptr_reg] : '0;
  assign init_done  = init_done_reg;

  always_comb begin
    state_next     = state_reg;
    init_ptr_next  = init_ptr_reg;
    init_done_next = init_done_reg;
    sram_en        = 1'b0;
    sram_wmode     = 1'b0;
    sram_addr      = '0;
    sram_wmask     = '0;
    sram_wdata     = '0;
    case (state_reg)
      ST_INIT: begin
        if (!reset) begin
          sram_en       = 1'b1;
          sram_wmode    = 1'b1;
          sram_wmask    = '1;
          sram_addr     = init_ptr_reg;
          init_ptr_next = init_ptr_reg + 1'b1;
          if (init_ptr_reg == '1) begin
            state_next     = ST_RUN;
            init_done_next = 1'b1;
          end
        end
      end
      ST_RUN: begin
        init_done_next = 1'b1;
        if (accept) begin
          sram_en    = 1'b1;
          sram_wmode = req_write;
          sram_addr  = req_addr;
          sram_wmask = req_wmask;
          sram_wdata = req_wdata;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= INIT_ON_RESET ? ST_INIT : ST_RUN;
      init_ptr_reg  <= '0;
      init_done_reg <= 1'b0;
      inflight_reg  <= 1'b0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      occ_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      init_ptr_reg  <= init_ptr_next;
      init_done_reg <= init_done_next;
      inflight_reg  <= accept && !req_write;
      if (push) begin
        wr_ptr_reg <= next_slot(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= next_slot(rd_ptr_reg);
      end
      occ_reg <= occ_reg + OCC_W'(push) - OCC_W'(pop);
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      fifo_mem[wr_ptr_reg] <= sram_rdata;
    end
  end

endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// Self-checking bench: SRAM macro model, per-cycle reference model of the
// controller's observable behaviour, directed scenarios and random traffic.
module tb_sram_rw_port_ctrl;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int MASK_W = 4;
  localparam int DEPTH  = 3;
  localparam int WORDS  = 256;

  logic              clock = 1'b0;
  logic              reset;
  logic              req_valid, req_ready, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;
  logic              resp_valid, resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              init_done;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_en, sram_wmode;
  logic [MASK_W-1:0] sram_wmask;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  always #5 clock = ~clock;

  sram_rw_port_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W),
    .RESP_DEPTH(DEPTH), .INIT_ON_RESET(1'b1)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .init_done(init_done),
    .sram_addr(sram_addr), .sram_en(sram_en), .sram_wmode(sram_wmode),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // Macro model: registered read, per-lane masked write.
  logic [DATA_W-1:0] sram_mem [WORDS];
  initial begin
    for (int i = 0; i < WORDS; i++) sram_mem[i] = 8'($urandom);
    sram_rdata = '0;
  end
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        for (int l = 0; l < MASK_W; l++)
          if (sram_wmask[l]) sram_mem[sram_addr][l*2 +: 2] <= sram_wdata[l*2 +: 2];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old, input logic [DATA_W-1:0] wd,
                                             input logic [MASK_W-1:0] m);
    logic [DATA_W-1:0] bits;
    bits = '0;
    for (int l = 0; l < MASK_W; l++)
      if (m[l]) bits = bits | (DATA_W'(2'b11) << (l * 2));
    return (old & ~bits) | (wd & bits);
  endfunction

  // Reference model: contents as seen by requests, and outstanding reads with
  // the cycle from which each may first be presented.
  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  logic [DATA_W-1:0] ref_mem [WORDS];
  exp_t              q[$];
  int                cyc = 0;
  bit                armed = 0;
  bit                in_init = 0;
  int                init_cnt = 0;
  bit                done_exp = 0;

  always @(negedge clock) begin : compare
    bit rv_exp, rr_exp, acc;
    cyc++;
    acc = 0;
    if (armed) begin
      rv_exp = (q.size() > 0) && (q[0].due <= cyc);
      rr_exp = done_exp && !reset && (q.size() < DEPTH);
      chk("req_ready", 32'(req_ready), 32'(rr_exp));
      chk("resp_valid", 32'(resp_valid), 32'(rv_exp));
      if (rv_exp) chk("resp_rdata", 32'(resp_rdata), 32'(q[0].data));
      else        chk("resp_rdata_idle", 32'(resp_rdata), 32'h0);
      chk("init_done", 32'(init_done), 32'(done_exp));
      if (reset) begin
        chk("sram_en_in_reset", 32'(sram_en), 32'h0);
      end else if (in_init) begin
        chk("init_port", 32'({sram_en, sram_wmode, sram_wmask, sram_wdata, sram_addr}),
            32'({1'b1, 1'b1, 4'hF, 8'h00, 8'(init_cnt)}));
      end else begin
        acc = req_valid && rr_exp;
        if (acc)
          chk("run_port", 32'({sram_en, sram_wmode, sram_wmask, sram_wdata, sram_addr}),
              32'({1'b1, req_write, req_wmask, req_wdata, req_addr}));
        else
          chk("idle_port", 32'({sram_en, sram_wmode, sram_wmask, sram_wdata, sram_addr}), 32'h0);
      end
      if (rv_exp && resp_ready) void'(q.pop_front());
    end
    if (reset) begin
      armed = 1;
      q.delete();
      in_init = 1;
      init_cnt = 0;
      done_exp = 0;
    end else if (armed && in_init) begin
      ref_mem[init_cnt] = '0;
      init_cnt++;
      if (init_cnt == WORDS) begin
        in_init = 0;
        done_exp = 1;
      end
    end else if (acc) begin
      if (req_write) ref_mem[req_addr] = merge(ref_mem[req_addr], req_wdata, req_wmask);
      else           q.push_back('{data: ref_mem[req_addr], due: cyc + 2});
    end
  end

  task automatic do_req(input bit w, input logic [7:0] a, input logic [7:0] d, input logic [3:0] m);
    bit got;
    got = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wmask = m;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (req_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("req_accept_timeout", 32'h0, 32'h1);
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output logic [7:0] d, output int k);
    d = '0;
    k = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      k++;
      if (resp_valid) begin
        d = resp_rdata;
        return;
      end
    end
    k = -1;
  endtask

  task automatic wait_init(output int n, output int en_cnt);
    n = 0;
    en_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      n++;
      if (sram_en) en_cnt++;
      if (init_done) return;
    end
    n = -1;
  endtask

  initial begin
    logic [7:0] d;
    int k, n, en_cnt, acc_n, drops;
    reset = 1'b1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wmask = 0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_outputs", 32'({req_ready, resp_valid, resp_rdata, init_done, sram_en}), 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    wait_init(n, en_cnt);
    chk("init_done_cycle", 32'(n), 32'd257);
    chk("init_write_count", 32'(en_cnt), 32'd256);
    @(posedge clock); #1;

    do_req(1'b0, 8'h77, 8'h00, 4'h0);
    wait_resp(d, k);
    chk("zero_after_init", 32'(d), 32'h00);

    do_req(1'b1, 8'h10, 8'hA5, 4'hF);
    do_req(1'b0, 8'h10, 8'h00, 4'h0);
    wait_resp(d, k);
    chk("raw_latency", 32'(k), 32'd2);
    chk("raw_data", 32'(d), 32'hA5);
    @(posedge clock); #1;

    do_req(1'b1, 8'h20, 8'hFF, 4'hF);
    do_req(1'b1, 8'h20, 8'h00, 4'h5);
    do_req(1'b0, 8'h20, 8'h00, 4'h0);
    wait_resp(d, k);
    chk("partial_mask", 32'(d), 32'hCC);
    @(posedge clock); #1;

    // Read followed by a write to the same word must return the old value.
    do_req(1'b0, 8'h10, 8'h00, 4'h0);
    do_req(1'b1, 8'h10, 8'h3C, 4'hF);
    wait_resp(d, k);
    chk("war_old_data", 32'(d), 32'hA5);
    @(posedge clock); #1;

    for (int i = 0; i < 5; i++) do_req(1'b1, 8'(8'h30 + i), 8'(8'h50 + i), 4'hF);
    resp_ready = 1'b0;
    acc_n = 0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h30;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (req_ready) acc_n++;
      @(posedge clock); #1;
      req_addr = 8'(8'h30 + acc_n);
    end
    chk("backpressure_accepts", 32'(acc_n), 32'd3);
    @(negedge clock);
    chk("backpressure_ready_low", 32'(req_ready), 32'h0);
    @(posedge clock); #1;
    resp_ready = 1'b1;
    for (int i = 0; i < 20 && acc_n < 5; i++) begin
      @(negedge clock);
      if (req_ready) acc_n++;
      @(posedge clock); #1;
      req_addr = 8'(8'h30 + acc_n);
    end
    req_valid = 1'b0;
    chk("backpressure_total", 32'(acc_n), 32'd5);
    repeat (4) @(posedge clock); #1;

    acc_n = 0;
    drops = 0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h40;
    for (int i = 0; i < 200 && acc_n < 100; i++) begin
      @(negedge clock);
      if (req_ready) acc_n++;
      else drops++;
      @(posedge clock); #1;
      req_addr = 8'(8'h40 + acc_n);
    end
    req_valid = 1'b0;
    chk("stream_reads", 32'(acc_n), 32'd100);
    chk("stream_ready_drops", 32'(drops), 32'd0);
    repeat (4) @(posedge clock); #1;

    for (int i = 0; i < 1500; i++) begin
      req_valid  = ($urandom_range(0, 2) != 0);
      req_write  = $urandom_range(0, 1) == 1;
      req_addr   = 8'($urandom_range(0, 15));
      req_wdata  = 8'($urandom);
      req_wmask  = 4'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clock); #1;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    repeat (5) @(posedge clock); #1;

    // Reset while the fill is halfway through.
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (sram_en && sram_addr == 8'h7F) break;
      n++;
    end
    chk("reach_init_0x7f", 32'(n), 32'd127);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("init_restart", 32'({sram_en, sram_addr}), 32'({1'b1, 8'h00}));
    wait_init(n, en_cnt);
    chk("reinit_done_cycle", 32'(n), 32'd256);
    @(posedge clock); #1;

    // Reset with two queued responses and one read in flight.
    resp_ready = 1'b0;
    acc_n = 0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10;
    for (int i = 0; i < 20 && acc_n < 3; i++) begin
      @(negedge clock);
      if (req_ready) acc_n++;
      @(posedge clock); #1;
    end
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    chk("pre_reset_valid", 32'(resp_valid), 32'h1);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("flush_resp_valid", 32'({resp_valid, req_ready}), 32'h0);
    chk("run_reset_restart", 32'({sram_en, sram_addr}), 32'({1'b1, 8'h00}));
    resp_ready = 1'b1;
    wait_init(n, en_cnt);
    chk("run_reset_init_done", 32'(n), 32'd256);
    @(posedge clock); #1;
    do_req(1'b0, 8'h10, 8'h00, 4'h0);
    wait_resp(d, k);
    chk("zero_after_reinit", 32'(d), 32'h00);
    repeat (3) @(posedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
